// File: rtl/decode_issue_if.sv
// -----------------------------------------------------------------------------
// decode_issue_if
// Bundles the fetch, decoder, execute and writeback signals of the decode/issue
// controller.
//   master : the surrounding pipeline (drives fetch, execute-ready, writeback
//            and flush; observes everything the controller produces)
//   slave  : decode_issue_ctrl
// Signals:
//   in_valid/in_instr/in_ready : fetch -> controller handshake
//   dec_enable/dec_instr       : decoder enable pulse and instruction word
//   ex_valid/ex_ready          : controller -> execute handshake
//   wb_valid/wb_rd             : writeback completion
//   flush                      : abandon current instruction, clear scoreboard
//   busy_vec/inflight          : scoreboard state
//   illegal/stall_hazard       : status
// -----------------------------------------------------------------------------
interface decode_issue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        dec_enable;
    logic [31:0] dec_instr;
    logic        ex_valid;
    logic        ex_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_vec;
    logic [4:0]  inflight;
    logic        illegal;
    logic        stall_hazard;

    modport master (
        output in_valid, in_instr, ex_ready, wb_valid, wb_rd, flush,
        input  in_ready, dec_enable, dec_instr, ex_valid, busy_vec, inflight,
               illegal, stall_hazard
    );

    modport slave (
        input  in_valid, in_instr, ex_ready, wb_valid, wb_rd, flush,
        output in_ready, dec_enable, dec_instr, ex_valid, busy_vec, inflight,
               illegal, stall_hazard
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
// Accepts one RV32I instruction at a time from fetch, pulses the decoder enable,
// waits DEC_LAT cycles for the decoder, then offers the result to execute.
// A register scoreboard holds off RAW/WAW hazards against destinations still
// awaiting writeback, and caps outstanding writebacks at MAX_INFLIGHT.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-high reset
//   bus  : decode_issue_if.slave (fetch, decoder, execute, writeback, status)
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int DEC_LAT      = 2,  // 1..15
    parameter int MAX_INFLIGHT = 4   // 1..31
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_if.slave        bus
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [3:0]  CNT_INIT = 4'(DEC_LAT - 1);
    localparam logic [4:0]  MAX_CNT  = 5'(MAX_INFLIGHT);

    typedef enum logic [1:0] {IDLE, DECODE, ISSUE} state_e;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_ILL} fmt_e;

    state_e      state_q, state_next;
    logic [3:0]  cnt_q, cnt_next;
    logic [31:0] dec_instr_q;
    logic        dec_enable_q;
    logic        illegal_q;
    logic [31:0] busy_q, busy_next;
    logic [4:0]  inflight_q;

    // ---------------------------------------------------------------- decode
    fmt_e       fmt;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd, illegal_op;
    logic       hazard, full, idle, accept, accept_legal;
    logic       set_busy, clr_busy;

    assign rs1 = bus.in_instr[19:15];
    assign rs2 = bus.in_instr[24:20];
    assign rd  = bus.in_instr[11:7];

    // NOTE: every signal assigned in an always_comb gets a default up front,
    // so no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        fmt = FMT_ILL;
        case (bus.in_instr[6:0])
            7'b0110011:                         fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
            7'b0100011:                         fmt = FMT_S;
            7'b1100011:                         fmt = FMT_B;
            7'b1101111:                         fmt = FMT_J;
            7'b0110111, 7'b0010111:             fmt = FMT_U;
            default:                            fmt = FMT_ILL;
        endcase
    end

    assign illegal_op = (fmt == FMT_ILL);
    assign uses_rs1   = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign uses_rs2   = fmt inside {FMT_R, FMT_S, FMT_B};
    assign writes_rd  = (fmt inside {FMT_R, FMT_I, FMT_J, FMT_U}) && (rd != 5'd0);

    // Hazard looks only at the registered scoreboard: a writeback landing this
    // cycle frees the register one cycle later, never combinationally.
    assign hazard = (uses_rs1  && busy_q[rs1]) ||
                    (uses_rs2  && busy_q[rs2]) ||
                    (writes_rd && busy_q[rd]);
    assign full   = (inflight_q == MAX_CNT) && writes_rd;

    assign idle             = (state_q == IDLE);
    // Illegal opcodes are always consumed (and dropped) so they cannot block fetch.
    assign bus.in_ready     = idle && !bus.flush && (illegal_op || (!hazard && !full));
    assign bus.stall_hazard = idle && bus.in_valid && !bus.flush && !illegal_op && (hazard || full);

    assign accept       = bus.in_valid && bus.in_ready;
    assign accept_legal = accept && !illegal_op;

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state_q <= state_next;
            cnt_q   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_q;
        cnt_next   = cnt_q;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_legal) begin
                        state_next = DECODE;
                        cnt_next   = CNT_INIT;
                    end
                end
                DECODE: begin
                    if (cnt_q == 4'd0) state_next = ISSUE;
                    else               cnt_next   = cnt_q - 4'd1;
                end
                ISSUE: begin
                    if (bus.ex_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.ex_valid = (state_q == ISSUE);

    // ------------------------------------------------------------- scoreboard
    assign set_busy = accept_legal && writes_rd;
    assign clr_busy = bus.wb_valid && (bus.wb_rd != 5'd0) && busy_q[bus.wb_rd];

    // Clear first, then set: a same-register set overrides the clear.
    always_comb begin
        busy_next = busy_q;
        if (clr_busy) busy_next[bus.wb_rd] = 1'b0;
        if (set_busy) busy_next[rd]        = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_instr_q  <= NOP;
            dec_enable_q <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= '0;
            inflight_q   <= '0;
        end else if (bus.flush) begin
            // dec_instr is deliberately held across a flush.
            dec_enable_q <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= '0;
            inflight_q   <= '0;
        end else begin
            dec_enable_q <= accept_legal;
            illegal_q    <= accept && illegal_op;
            if (accept_legal) dec_instr_q <= bus.in_instr;
            busy_q <= busy_next;
            case ({set_busy, clr_busy})
                2'b10:   inflight_q <= inflight_q + 5'd1;
                2'b01:   inflight_q <= inflight_q - 5'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    assign bus.dec_instr  = dec_instr_q;
    assign bus.dec_enable = dec_enable_q;
    assign bus.illegal    = illegal_q;
    assign bus.busy_vec   = busy_q;
    assign bus.inflight   = inflight_q;

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Sequences the RV32I decoder and hands decoded operands to execute. Accepts one instruction at a time from fetch over a valid/ready handshake and pulses the decoder enable. After a fixed decode latency it presents the result to execute over a valid/ready handshake. A register scoreboard stalls RAW/WAW hazards against destination registers still awaiting writeback.

Parameters:
DEC_LAT, 2, cycles from the dec_enable pulse to decoder outputs valid (1..15)
MAX_INFLIGHT, 4, maximum issued instructions with rd!=0 awaiting writeback (1..31)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch has instruction
in_instr  in  32  instruction word
in_ready  out  1  controller accepts in_instr this cycle
dec_enable  out  1  one-cycle pulse to decoder
dec_instr  out  32  registered instruction driven to decoder
ex_valid  out  1  decoded operands valid for execute
ex_ready  in  1  execute accepts
wb_valid  in  1  writeback completing
wb_rd  in  5  writeback destination register
flush  in  1  abandon current instruction and clear scoreboard
busy_vec  out  32  scoreboard, bit n = xn pending writeback
inflight  out  5  count of pending writebacks
illegal  out  1  one-cycle pulse: unsupported opcode dropped
stall_hazard  out  1  valid legal instruction held off by hazard or full

Behaviour:
- Reset (async, rst=1): state IDLE; dec_instr=32'h00000013 (NOP); dec_enable=0, ex_valid=0, illegal=0; busy_vec=0; inflight=0.
- Format classification from in_instr[6:0]:
  - R: 0110011
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - J: 1101111
  - U: 0110111, 0010111
  - Any other opcode is illegal.
- Operand and destination usage:
  - uses_rs1: R, I, S, B.
  - uses_rs2: R, S, B.
  - writes_rd: R, I, J, U, only when rd!=0.
- Fields: rs1=[19:15], rs2=[24:20], rd=[11:7].
- hazard = (uses_rs1 & busy_vec[rs1]) | (uses_rs2 & busy_vec[rs2]) | (writes_rd & busy_vec[rd]).
  - hazard uses the registered busy_vec only; no same-cycle writeback bypass.
  - busy_vec[0] is always 0.
- full = (inflight == MAX_INFLIGHT) & writes_rd.
- in_ready = (state==IDLE) & !flush & (illegal_op | (!hazard & !full)). Combinational.
- stall_hazard = (state==IDLE) & in_valid & !flush & !illegal_op & (hazard | full).
- State IDLE:
  - On accept of a legal instruction: dec_instr<=in_instr; dec_enable=1 for the next cycle; if writes_rd, set busy_vec[rd]; go to DECODE with cnt=DEC_LAT-1.
  - On accept of an illegal instruction: illegal=1 for the next cycle; stay in IDLE; dec_instr and scoreboard unchanged.
- State DECODE: cnt decrements each cycle; at cnt==0 go to ISSUE.
  - Timing: ex_valid rises exactly DEC_LAT cycles after the dec_enable cycle.
- State ISSUE:
  - ex_valid=1 and dec_instr stable until ex_valid & ex_ready; then go to IDLE with ex_valid=0 the next cycle.
  - ex_ready while not ex_valid is ignored.
- Throughput: at most one instruction per DEC_LAT+2 cycles; in_ready is never 1 while ex_valid is 1.
- Writeback:
  - wb_valid with wb_rd!=0 and busy_vec[wb_rd]=1 clears the bit and decrements inflight.
  - Writeback to x0 or to a non-busy register is ignored.
  - Processed in every state.
- Inflight counter:
  - Increments on accept when writes_rd.
  - Simultaneous increment and decrement leaves it unchanged.
  - Never exceeds MAX_INFLIGHT.
- Same-cycle writeback clear and accept set on the same register: set wins, bit stays 1, inflight unchanged.
- flush (any state, highest priority over accept/writeback/ex_ready):
  - Next cycle: state IDLE, ex_valid=0, dec_enable=0, busy_vec=0, inflight=0.
  - dec_instr is held.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
1. Issue ADD x5,x1,x2 (0x002082B3), DEC_LAT=2, ex_ready=1 → dec_enable pulse at cycle t+1; ex_valid at t+3 for 1 cycle; busy_vec=0x20; inflight=1.
2. RAW stall:
   - After test 1 with no writeback, present ADDI x6,x5,1 → stall_hazard=1, in_ready=0.
   - wb_valid=1, wb_rd=5 in cycle k → busy_vec=0 at k+1; in_ready=1 at k+1, not at k.
3. Full:
   - MAX_INFLIGHT=4; issue writes to x1..x4 with no writeback; present ADDI x7,x0,1 → stall_hazard=1.
   - Present SW x1,0(x2) → still stalled (RAW on x1).
   - Present BEQ x0,x0 → accepted (no rd).
4. Simultaneous events:
   - Writeback wb_rd=9 in the same cycle as accepting LUI x9 with x9 previously busy-free → busy_vec[9]=1, inflight +1.
   - With x9 pending: writeback x9 concurrent with accepting ADD x3,x0,x0 → inflight unchanged, busy_vec[9]=0, busy_vec[3]=1.
5. Illegal and x0:
   - Present 0x0000007F → illegal pulse, in_ready=1, busy_vec unchanged, no dec_enable.
   - ADD x0,x1,x2 → no busy bit set, inflight unchanged.
6. Flush and reset:
   - Assert flush in ISSUE with ex_ready=0 → next cycle ex_valid=0, busy_vec=0, inflight=0.
   - Assert rst asynchronously mid-DECODE → outputs at reset values before the next clk edge.
